// File: rtl/l2_write_buffer.sv
// l2_write_buffer
//   Single-line write buffer between the L1 downstream line port and physical
//   memory. An evicted line is absorbed in one cycle and drained to memory in
//   the background. Reads hit the buffered line first; otherwise they fetch
//   from physical memory.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   mem_read/mem_write           L1 requests, held until mem_resp
//   mem_address, mem_wdata       L1 request address (offset ignored) and line
//   mem_resp, mem_rdata          one-cycle completion pulse and read line
//   pmem_read/pmem_write         physical memory strobes, held until pmem_resp
//   pmem_address, pmem_wdata     line-aligned address and line being drained
//   pmem_resp, pmem_rdata        physical memory completion and read line
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | sample L1 requests; start a background drain when quiet
// RESP  | mem_resp high for one cycle, requests not sampled
// FETCH | pmem_read outstanding for a buffer miss
// DRAIN | pmem_write of the buffered line outstanding, never aborted

module l2_write_buffer #(
   parameter int ADDR_WIDTH  = 16,
   parameter int LINE_WIDTH  = 128,
   parameter int OFFSET_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [LINE_WIDTH-1:0] mem_wdata,
   output logic                  mem_resp,
   output logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata
);

   localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

   typedef enum logic [1:0] {IDLE, RESP, FETCH, DRAIN} state_t;

   state_t                 state;
   logic                   buf_valid;
   logic [TAG_WIDTH-1:0]   buf_tag;
   logic [LINE_WIDTH-1:0]  buf_data;

   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   buf_hit;
   logic                   unused_offset;

   assign req_tag       = mem_address[ADDR_WIDTH-1:OFFSET_BITS];
   assign buf_hit       = buf_valid && (buf_tag == req_tag);
   assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         buf_valid    <= 1'b0;
         buf_tag      <= '0;
         buf_data     <= '0;
         mem_resp     <= 1'b0;
         mem_rdata    <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_read) begin
                  if (buf_hit) begin
                     mem_rdata <= buf_data;
                     mem_resp  <= 1'b1;
                     state     <= RESP;
                  end else begin
                     pmem_read    <= 1'b1;
                     pmem_address <= {req_tag, {OFFSET_BITS{1'b0}}};
                     state        <= FETCH;
                  end
               end else if (mem_write) begin
                  if (!buf_valid || buf_hit) begin
                     buf_tag   <= req_tag;
                     buf_data  <= mem_wdata;
                     buf_valid <= 1'b1;
                     mem_resp  <= 1'b1;
                     state     <= RESP;
                  end else begin
                     // conflicting line: drain it first, the write stays pending
                     pmem_write   <= 1'b1;
                     pmem_address <= {buf_tag, {OFFSET_BITS{1'b0}}};
                     pmem_wdata   <= buf_data;
                     state        <= DRAIN;
                  end
               end else if (buf_valid) begin
                  pmem_write   <= 1'b1;
                  pmem_address <= {buf_tag, {OFFSET_BITS{1'b0}}};
                  pmem_wdata   <= buf_data;
                  state        <= DRAIN;
               end
            end
            RESP: begin
               mem_resp <= 1'b0;
               state    <= IDLE;
            end
            FETCH: begin
               if (pmem_resp) begin
                  pmem_read <= 1'b0;
                  mem_rdata <= pmem_rdata;
                  mem_resp  <= 1'b1;
                  state     <= RESP;
               end
            end
            DRAIN: begin
               if (pmem_resp) begin
                  pmem_write <= 1'b0;
                  buf_valid  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_read_and_write: assert property (@(posedge clk) disable iff (!reset_n)
      !(mem_read && mem_write));

   a_one_pmem_strobe: assert property (@(posedge clk) disable iff (!reset_n)
      !(pmem_read && pmem_write));

endmodule

// File: tb/tb_l2_write_buffer.sv
module tb_l2_write_buffer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         mem_read, mem_write;
   logic [15:0]  mem_address;
   logic [127:0] mem_wdata;
   logic         mem_resp;
   logic [127:0] mem_rdata;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;

   int vectors = 0;
   int miscompares = 0;

   // physical memory model
   logic         pmem_en;
   int           pmem_lat;
   int           lat_left;
   logic [127:0] pmem_mem [logic [11:0]];
   logic [15:0]  wlog_addr [$];
   logic [127:0] wlog_data [$];

   // L1's view of memory: last written line per tag
   logic [127:0] l1_view [logic [11:0]];

   always #5 clk = ~clk;

   l2_write_buffer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   function automatic logic [127:0] init_line(input logic [11:0] t);
      return {4{20'hA5A5A, t}};
   endfunction

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // advance one clock; emulate physical memory when enabled
   task automatic step();
      logic [11:0] t;
      if (pmem_en) begin
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            lat_left  = pmem_lat;
         end else if (pmem_read || pmem_write) begin
            if (lat_left == 0) begin
               pmem_resp = 1'b1;
               t = pmem_address[15:4];
               if (pmem_write) begin
                  pmem_mem[t] = pmem_wdata;
                  wlog_addr.push_back(pmem_address);
                  wlog_data.push_back(pmem_wdata);
               end else begin
                  pmem_rdata = pmem_mem.exists(t) ? pmem_mem[t] : init_line(t);
               end
            end else begin
               lat_left--;
            end
         end else begin
            lat_left = pmem_lat;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (30) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      vectors++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: got resp=%b prd=%b pwr=%b want 0 0 0", mem_resp, pmem_read, pmem_write);
      end
      vectors++;
      if (mem_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h want zeros", mem_rdata, pmem_address, pmem_wdata);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_write_drain();
      logic [127:0] l = rand_line();
      int n;
      pmem_lat = 3;
      mem_address = 16'h1234; mem_wdata = l; mem_write = 1'b1;
      step();
      vectors++;
      if (mem_resp !== 1'b1) begin
         miscompares++;
         $display("FAIL write_latency: got mem_resp=%b want 1", mem_resp);
      end
      mem_write = 1'b0;
      n = 0;
      while (!pmem_write && n < 20) begin step(); n++; end
      vectors++;
      if (pmem_write !== 1'b1 || pmem_address !== 16'h1230 || pmem_wdata !== l) begin
         miscompares++;
         $display("FAIL drain_1: got pwr=%b addr=%h data=%h want 1 1230 %h", pmem_write, pmem_address, pmem_wdata, l);
      end
      n = 0;
      while (pmem_write && n < 20) begin step(); n++; end
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++;
         if (pmem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_once: got pmem_write=%b want 0 at cycle %0d", pmem_write, i);
         end
      end
   endtask

   task automatic test_read_hit();
      logic [127:0] l2 = rand_line();
      int n;
      pmem_lat = 2;
      mem_address = 16'h2000; mem_wdata = l2; mem_write = 1'b1;
      step();
      vectors++;
      if (mem_resp !== 1'b1) begin
         miscompares++;
         $display("FAIL hit_write_resp: got %b want 1", mem_resp);
      end
      mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h2008;
      step();
      vectors++;
      if (mem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL hit_resp_gap: got mem_resp=%b want 0", mem_resp);
      end
      step();
      vectors++;
      if (mem_resp !== 1'b1 || mem_rdata !== l2 || pmem_read !== 1'b0) begin
         miscompares++;
         $display("FAIL read_hit: got resp=%b data=%h prd=%b want 1 %h 0", mem_resp, mem_rdata, pmem_read, l2);
      end
      mem_read = 1'b0;
      settle();
   endtask

   task automatic test_read_fetch();
      logic [127:0] d = rand_line();
      int n;
      pmem_mem[12'h400] = d;
      pmem_lat = 5;
      step();
      mem_address = 16'h4006; mem_read = 1'b1;
      n = 0;
      while (!pmem_read && n < 20) begin step(); n++; end
      vectors++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h4000) begin
         miscompares++;
         $display("FAIL fetch_addr: got prd=%b addr=%h want 1 4000", pmem_read, pmem_address);
      end
      n = 0;
      while (!mem_resp && n < 50) begin step(); n++; end
      vectors++;
      if (n !== pmem_lat + 1) begin
         miscompares++;
         $display("FAIL fetch_latency: got %0d cycles want %0d", n, pmem_lat + 1);
      end
      vectors++;
      if (mem_resp !== 1'b1 || mem_rdata !== d) begin
         miscompares++;
         $display("FAIL fetch_data: got resp=%b data=%h want 1 %h", mem_resp, mem_rdata, d);
      end
      mem_read = 1'b0;
      settle();
   endtask

   task automatic test_conflict_write();
      logic [127:0] l3 = rand_line();
      logic [127:0] l5 = rand_line();
      int base = wlog_addr.size();
      int n;
      pmem_lat = 2;
      mem_address = 16'h3000; mem_wdata = l3; mem_write = 1'b1;
      step();
      mem_address = 16'h5000; mem_wdata = l5;
      n = 0;
      do begin step(); n++; end while (!mem_resp && n < 50);
      vectors++;
      if (wlog_addr.size() !== base + 1) begin
         miscompares++;
         $display("FAIL conflict_order: got %0d drains before resp want %0d", wlog_addr.size() - base, 1);
      end else begin
         vectors++;
         if (wlog_addr[base] !== 16'h3000 || wlog_data[base] !== l3) begin
            miscompares++;
            $display("FAIL conflict_drain: got %h/%h want 3000/%h", wlog_addr[base], wlog_data[base], l3);
         end
      end
      vectors++;
      if (mem_resp !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_resp: got mem_resp=%b want 1", mem_resp);
      end
      mem_write = 1'b0;
      n = 0;
      while (wlog_addr.size() < base + 2 && n < 50) begin step(); n++; end
      vectors++;
      if (wlog_addr.size() !== base + 2) begin
         miscompares++;
         $display("FAIL conflict_l5_drain: got %0d drains want 2", wlog_addr.size() - base);
      end else begin
         vectors++;
         if (wlog_addr[base+1] !== 16'h5000 || wlog_data[base+1] !== l5) begin
            miscompares++;
            $display("FAIL conflict_l5_data: got %h/%h want 5000/%h", wlog_addr[base+1], wlog_data[base+1], l5);
         end
      end
      settle();
   endtask

   task automatic test_merge_write();
      logic [127:0] a = rand_line();
      logic [127:0] b = rand_line();
      int base = wlog_addr.size();
      int n;
      pmem_lat = 1;
      mem_address = 16'h6000; mem_wdata = a; mem_write = 1'b1;
      step();
      mem_wdata = b;
      n = 0;
      do begin step(); n++; end while (!mem_resp && n < 50);
      vectors++;
      if (n !== 2) begin
         miscompares++;
         $display("FAIL merge_latency: got %0d cycles want 2", n);
      end
      mem_write = 1'b0;
      settle();
      vectors++;
      if (wlog_addr.size() !== base + 1) begin
         miscompares++;
         $display("FAIL merge_count: got %0d pmem writes want 1", wlog_addr.size() - base);
      end else begin
         vectors++;
         if (wlog_addr[base] !== 16'h6000 || wlog_data[base] !== b) begin
            miscompares++;
            $display("FAIL merge_data: got %h/%h want 6000/%h", wlog_addr[base], wlog_data[base], b);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int n;
      pmem_en = 1'b0;
      pmem_resp = 1'b0;
      mem_address = 16'h7000; mem_wdata = rand_line(); mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      n = 0;
      while (!pmem_write && n < 20) begin step(); n++; end
      vectors++;
      if (pmem_write !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_drain_start: got pmem_write=%b want 1", pmem_write);
      end
      reset_n = 1'b0;
      step();
      vectors++;
      if (pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_drain: got pwr=%b resp=%b want 0 0", pmem_write, mem_resp);
      end
      reset_n = 1'b1;
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++;
         if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_late_resp: got pwr=%b prd=%b resp=%b want 0 0 0", pmem_write, pmem_read, mem_resp);
         end
      end
      lat_left = pmem_lat;
      pmem_en = 1'b1;
   endtask

   task automatic test_random();
      logic [11:0]  tag;
      logic [127:0] exp, line;
      logic         is_wr, got;
      for (int k = 0; k < 60; k++) begin
         tag = 12'h800 + 12'($urandom_range(0, 7));
         mem_address = {tag, 4'($urandom_range(0, 15))};
         is_wr = 1'($urandom_range(0, 1));
         pmem_lat = $urandom_range(0, 4);
         exp = '0;
         if (is_wr) begin
            line = rand_line();
            mem_wdata = line;
            l1_view[tag] = line;
            mem_write = 1'b1;
         end else begin
            exp = l1_view.exists(tag) ? l1_view[tag] : init_line(tag);
            mem_read = 1'b1;
         end
         got = 1'b0;
         for (int c = 0; c < 100 && !got; c++) begin
            step();
            vectors++;
            if ((pmem_read && pmem_write) || ((pmem_read || pmem_write) && pmem_address[3:0] != 4'h0)) begin
               miscompares++;
               $display("FAIL rnd_pmem_rule: got prd=%b pwr=%b addr=%h", pmem_read, pmem_write, pmem_address);
            end
            if (mem_resp) got = 1'b1;
         end
         vectors++;
         if (got !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd_timeout: txn %0d got no mem_resp want mem_resp", k);
         end else if (!is_wr) begin
            vectors++;
            if (mem_rdata !== exp) begin
               miscompares++;
               $display("FAIL rnd_read: txn %0d tag %h got %h want %h", k, tag, mem_rdata, exp);
            end
         end
         mem_read = 1'b0;
         mem_write = 1'b0;
         repeat ($urandom_range(0, 3)) step();
      end
      settle();
      foreach (l1_view[t]) begin
         vectors++;
         if (!pmem_mem.exists(t) || pmem_mem[t] !== l1_view[t]) begin
            miscompares++;
            $display("FAIL rnd_final_mem: tag %h got %h want %h", t,
                     pmem_mem.exists(t) ? pmem_mem[t] : 128'h0, l1_view[t]);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;
      mem_address = '0; mem_wdata = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
      pmem_en = 1'b1; pmem_lat = 2; lat_left = 2;
      test_reset();
      test_write_drain();
      test_read_hit();
      test_read_fetch();
      test_conflict_write();
      test_merge_write();
      test_reset_mid_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
